// File: rtl/tmds_decoder_if.sv
// Symbol input and decoded output bundle for tmds_decoder.
// With TMDS_DECODER_STATS_EN defined the bundle also carries lock_loss_count.
interface tmds_decoder_if;
  logic [9:0]  sym_in;
  logic        sym_valid;
  logic [7:0]  data_out;
  logic        c0;
  logic        c1;
  logic        de;
  logic        valid_out;
  logic        locked;
  logic [3:0]  offset;
`ifdef TMDS_DECODER_STATS_EN
  logic [15:0] lock_loss_count;

  modport master (
    output sym_in, sym_valid,
    input  data_out, c0, c1, de, valid_out, locked, offset, lock_loss_count
  );
  modport slave (
    input  sym_in, sym_valid,
    output data_out, c0, c1, de, valid_out, locked, offset, lock_loss_count
  );
`else
  modport master (
    output sym_in, sym_valid,
    input  data_out, c0, c1, de, valid_out, locked, offset
  );
  modport slave (
    input  sym_in, sym_valid,
    output data_out, c0, c1, de, valid_out, locked, offset
  );
`endif
endinterface

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: word alignment search/lock plus 10b->8b decode.
// Optional macro TMDS_DECODER_STATS_EN adds a saturating lock_loss_count output.
module tmds_decoder #(
  parameter int unsigned LOCK_RUN = 64,
  parameter int unsigned WINDOW   = 2048
) (
  input  logic          clk,
  input  logic          rst,
  tmds_decoder_if.slave bus
);

  localparam int unsigned RUN_W = $clog2(LOCK_RUN + 1);
  localparam int unsigned WIN_W = $clog2(WINDOW + 1);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  logic [0:0]       state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [3:0]       offset_q, offset_d;
  logic             loss_event;

  logic [9:0]       prev_q;
  logic [19:0]      stream;
  logic [9:0]       aligned;
  logic             aligned_tok;

  logic             s1_valid_q;
  logic [9:0]       s1_word_q;

  logic [7:0]       t_byte;
  logic [7:0]       x_byte;
  logic [7:0]       dec_byte;

  logic [7:0]       data_q;
  logic             c0_q, c1_q, de_q, valid_q;

  // Rotation window over the current and previous symbol (bit 0 oldest).
  assign stream      = {bus.sym_in, prev_q};
  assign aligned     = 10'(stream >> offset_q);
  assign aligned_tok = (aligned == TOK_00) || (aligned == TOK_01) ||
                       (aligned == TOK_10) || (aligned == TOK_11);

  // Alignment FSM state and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SEARCH;
      run_q    <= '0;
      win_q    <= '0;
      offset_q <= '0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      win_q    <= win_d;
      offset_q <= offset_d;
      if (bus.sym_valid) prev_q <= bus.sym_in;
    end
  end

  // Next-state: qualifying token run wins over window expiry on the same symbol.
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    win_d      = win_q;
    offset_d   = offset_q;
    loss_event = 1'b0;
    if (bus.sym_valid) begin
      if (!aligned_tok)                     run_d = '0;
      else if (run_q != RUN_W'(LOCK_RUN))   run_d = run_q + 1'b1;
      win_d = win_q + 1'b1;
      if (run_d == RUN_W'(LOCK_RUN)) begin
        state_d = ST_LOCKED;
        win_d   = '0;
      end else if (win_d == WIN_W'(WINDOW)) begin
        loss_event = (state_q == ST_LOCKED);
        state_d    = ST_SEARCH;
        offset_d   = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
        run_d      = '0;
        win_d      = '0;
      end
    end
  end

  // Stage 1: capture the aligned word.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_word_q  <= '0;
    end else begin
      s1_valid_q <= bus.sym_valid;
      if (bus.sym_valid) s1_word_q <= aligned;
    end
  end

  // Data-period decode of the stage-1 word.
  always_comb begin
    t_byte   = s1_word_q[9] ? ~s1_word_q[7:0] : s1_word_q[7:0];
    x_byte   = t_byte ^ {t_byte[6:0], 1'b0};
    dec_byte = s1_word_q[8] ? x_byte : {~x_byte[7:1], t_byte[0]};
  end

  // Stage 2: registered outputs, updated only alongside valid_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      de_q    <= 1'b0;
      c0_q    <= 1'b0;
      c1_q    <= 1'b0;
    end else begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        de_q <= 1'b0;
        case (s1_word_q)
          TOK_00:  {c1_q, c0_q} <= 2'b00;
          TOK_01:  {c1_q, c0_q} <= 2'b01;
          TOK_10:  {c1_q, c0_q} <= 2'b10;
          TOK_11:  {c1_q, c0_q} <= 2'b11;
          default: begin
            de_q   <= 1'b1;
            data_q <= dec_byte;
          end
        endcase
      end
    end
  end

  assign bus.data_out  = data_q;
  assign bus.c0        = c0_q;
  assign bus.c1        = c1_q;
  assign bus.de        = de_q;
  assign bus.valid_out = valid_q;
  assign bus.locked    = (state_q == ST_LOCKED);
  assign bus.offset    = offset_q;

`ifdef TMDS_DECODER_STATS_EN
  logic [15:0] loss_cnt_q;

  // Saturating count of LOCKED->SEARCH transitions.
  always_ff @(posedge clk) begin
    if (rst)                                  loss_cnt_q <= '0;
    else if (loss_event && loss_cnt_q != 16'hFFFF) loss_cnt_q <= loss_cnt_q + 16'd1;
  end

  assign bus.lock_loss_count = loss_cnt_q;
`else
  logic unused_loss;
  assign unused_loss = loss_event;
`endif

endmodule
